fetch_decode: RTL and testbench

//  Multi-cycle fetch/decode/operand stage directly upstream of the ALU.

---
 rtl/fetch_decode_if.sv | 50 +++++
 rtl/fetch_decode.sv | 185 ++++++++++++++++++
 tb/tb_fetch_decode.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// Bundle of the imem fetch port, the decoded-operand handshake toward the ALU
// and the retire/writeback port coming back from downstream.
// The master side is the fetch/decode stage itself; the slave side is its environment.
interface fetch_decode_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        id_valid;
  logic        id_ready;
  logic [5:0]  id_opcode;
  logic [4:0]  id_shamt;
  logic [4:0]  id_funct;
  logic [31:0] id_s1;
  logic [31:0] id_s2;
  logic [15:0] id_const;
  logic [25:0] id_jump_addr;
  logic [15:0] id_pc;
  logic        id_wb_en;
  logic [4:0]  id_wb_dst;

  logic        ret_valid;
  logic        ret_wb_en;
  logic [31:0] ret_wb_data;
  logic        ret_redirect;
  logic [15:0] ret_pc_new;

  logic        illegal;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output id_valid, id_opcode, id_shamt, id_funct, id_s1, id_s2,
           id_const, id_jump_addr, id_pc, id_wb_en, id_wb_dst,
    input  id_ready,
    input  ret_valid, ret_wb_en, ret_wb_data, ret_redirect, ret_pc_new,
    output illegal
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  id_valid, id_opcode, id_shamt, id_funct, id_s1, id_s2,
           id_const, id_jump_addr, id_pc, id_wb_en, id_wb_dst,
    output id_ready,
    output ret_valid, ret_wb_en, ret_wb_data, ret_redirect, ret_pc_new,
    input  illegal
  );
endinterface

// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode/operand stage feeding the ALU. Owns the PC and the
// 32x32 register file and keeps exactly one instruction in flight:
// FETCH -> WAIT (for imem) -> ISSUE (to ALU) -> RETIRE (writeback, next PC).
module fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_decode_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_RETIRE
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic        r_imem_req;
  logic        r_illegal;
  logic        r_id_valid;
  logic [5:0]  r_id_opcode;
  logic [4:0]  r_id_shamt;
  logic [4:0]  r_id_funct;
  logic [31:0] r_id_s1;
  logic [31:0] r_id_s2;
  logic [15:0] r_id_const;
  logic [25:0] r_id_jump_addr;
  logic [15:0] r_id_pc;
  logic        r_id_wb_en;
  logic [4:0]  r_id_wb_dst;
  logic [31:0] r_rf [32];

  logic [5:0]  w_opcode;
  logic [4:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic        w_legal;
  logic        w_wb_en;
  logic [4:0]  w_wb_dst;
  logic [31:0] w_s1;
  logic [31:0] w_s2;
  logic [15:0] w_pc_next;
  logic        w_rf_we;

  assign w_opcode  = bus.imem_rdata[31:26];
  assign w_rs      = bus.imem_rdata[25:21];
  assign w_rt      = bus.imem_rdata[20:16];
  assign w_rd      = bus.imem_rdata[15:11];
  assign w_funct   = bus.imem_rdata[4:0];
  assign w_pc_next = r_pc + PC_INC;

  // r0 is hardwired to zero on the read side regardless of array contents
  assign w_s1 = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_s2 = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

  // Writeback only on the retire pulse of an instruction that owns a non-r0 destination
  assign w_rf_we = (r_state == S_RETIRE) && bus.ret_valid && bus.ret_wb_en &&
                   r_id_wb_en && (r_id_wb_dst != 5'd0);

  // Legality and destination-register selection from the raw instruction word
  always_comb begin
    w_legal  = 1'b0;
    w_wb_en  = 1'b0;
    w_wb_dst = 5'd0;
    if (w_opcode == 6'd0) begin
      w_legal  = (w_funct <= 5'd8);
      w_wb_en  = 1'b1;
      w_wb_dst = w_rd;
    end else if (w_opcode <= 6'd16) begin
      w_legal = 1'b1;
      if (w_opcode <= 6'd4) begin
        w_wb_en  = 1'b1;
        w_wb_dst = w_rs;
      end else if (w_opcode == 6'd16) begin
        w_wb_en  = 1'b1;
        w_wb_dst = w_rt;
      end
    end
  end

  // Register file: cleared on reset, written only when an instruction retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (w_rf_we) begin
      r_rf[r_id_wb_dst] <= bus.ret_wb_data;
    end
  end

  // Control FSM with registered request/valid/illegal outputs and the decoded bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_imem_req     <= 1'b0;
      r_illegal      <= 1'b0;
      r_id_valid     <= 1'b0;
      r_id_opcode    <= 6'd0;
      r_id_shamt     <= 5'd0;
      r_id_funct     <= 5'd0;
      r_id_s1        <= 32'd0;
      r_id_s2        <= 32'd0;
      r_id_const     <= 16'd0;
      r_id_jump_addr <= 26'd0;
      r_id_pc        <= 16'd0;
      r_id_wb_en     <= 1'b0;
      r_id_wb_dst    <= 5'd0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          r_state    <= S_WAIT;
          r_imem_req <= 1'b0;
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            if (w_legal) begin
              r_id_valid     <= 1'b1;
              r_id_opcode    <= w_opcode;
              r_id_shamt     <= bus.imem_rdata[10:6];
              r_id_funct     <= w_funct;
              r_id_s1        <= w_s1;
              r_id_s2        <= w_s2;
              r_id_const     <= bus.imem_rdata[15:0];
              r_id_jump_addr <= bus.imem_rdata[25:0];
              r_id_pc        <= w_pc_next;
              r_id_wb_en     <= w_wb_en;
              r_id_wb_dst    <= w_wb_dst;
              r_state        <= S_ISSUE;
            end else begin
              r_illegal  <= 1'b1;
              r_pc       <= w_pc_next;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_ISSUE: begin
          if (bus.id_ready) begin
            r_id_valid <= 1'b0;
            r_state    <= S_RETIRE;
          end
        end
        S_RETIRE: begin
          if (bus.ret_valid) begin
            r_pc       <= bus.ret_redirect ? bus.ret_pc_new : w_pc_next;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
          r_id_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req     = r_imem_req;
  assign bus.imem_addr    = r_pc;
  assign bus.illegal      = r_illegal;
  assign bus.id_valid     = r_id_valid;
  assign bus.id_opcode    = r_id_opcode;
  assign bus.id_shamt     = r_id_shamt;
  assign bus.id_funct     = r_id_funct;
  assign bus.id_s1        = r_id_s1;
  assign bus.id_s2        = r_id_s2;
  assign bus.id_const     = r_id_const;
  assign bus.id_jump_addr = r_id_jump_addr;
  assign bus.id_pc        = r_id_pc;
  assign bus.id_wb_en     = r_id_wb_en;
  assign bus.id_wb_dst    = r_id_wb_dst;

endmodule

// File: tb/tb_fetch_decode.sv
// Testbench for fetch_decode: a table of instructions with hand-decoded legality and
// destinations, a register-file/PC model, and a scoreboard queue of expected bundles.
module tb_fetch_decode;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_decode_if bus();

  fetch_decode #(
    .RESET_PC(16'h0000),
    .PC_INC  (16'd1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  typedef struct {
    logic [31:0] instr;
    logic        legal;
    logic        wbEn;
    logic [4:0]  wbDst;
    int          readyDelay;
    logic        retWbEn;
    logic [31:0] retData;
    logic        redirect;
    logic [15:0] pcNew;
  } vec_t;

  typedef struct {
    logic [5:0]  opcode;
    logic [4:0]  shamt;
    logic [4:0]  funct;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [15:0] cnst;
    logic [25:0] jump;
    logic [15:0] pc;
    logic        wbEn;
    logic [4:0]  wbDst;
    logic        legal;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          fetchCycle [16];
  exp_t        sbQ [$];
  logic [31:0] modelRf [32];
  logic [15:0] modelPc;
  vec_t        vecs [13];

  // Free-running cycle counter used for latency measurements
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) modelRf[i] = 32'd0;
    modelPc = 16'h0000;
  endtask

  task automatic checkBundle(input exp_t e);
    checkOutput("id_valid",     32'(bus.id_valid),     32'd1);
    checkOutput("id_opcode",    32'(bus.id_opcode),    32'(e.opcode));
    checkOutput("id_shamt",     32'(bus.id_shamt),     32'(e.shamt));
    checkOutput("id_funct",     32'(bus.id_funct),     32'(e.funct));
    checkOutput("id_s1",        bus.id_s1,             e.s1);
    checkOutput("id_s2",        bus.id_s2,             e.s2);
    checkOutput("id_const",     32'(bus.id_const),     32'(e.cnst));
    checkOutput("id_jump_addr", 32'(bus.id_jump_addr), 32'(e.jump));
    checkOutput("id_pc",        32'(bus.id_pc),        32'(e.pc));
    checkOutput("id_wb_en",     32'(bus.id_wb_en),     32'(e.wbEn));
    checkOutput("id_wb_dst",    32'(bus.id_wb_dst),    32'(e.wbDst));
    checkOutput("illegal_idle", 32'(bus.illegal),      32'd0);
  endtask

  // Runs one instruction through fetch, decode, optional ready stall and retire
  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    int   k;
    k = 0;
    while (!bus.imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("fetch_req", 32'(bus.imem_req), 32'd1);
    fetchCycle[idx] = cycle;
    checkOutput("fetch_addr", 32'(bus.imem_addr), 32'(modelPc));
    @(negedge clk);
    checkOutput("req_low_wait", 32'(bus.imem_req), 32'd0);
    checkOutput("illegal_clear", 32'(bus.illegal), 32'd0);
    e.opcode = v.instr[31:26];
    e.shamt  = v.instr[10:6];
    e.funct  = v.instr[4:0];
    e.s1     = modelRf[v.instr[25:21]];
    e.s2     = modelRf[v.instr[20:16]];
    e.cnst   = v.instr[15:0];
    e.jump   = v.instr[25:0];
    e.pc     = modelPc + 16'd1;
    e.wbEn   = v.wbEn;
    e.wbDst  = v.wbDst;
    e.legal  = v.legal;
    sbQ.push_back(e);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = v.instr;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    e = sbQ.pop_front();
    if (e.legal) begin
      checkBundle(e);
      for (int d = 0; d < v.readyDelay; d++) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = ~v.instr;
        bus.ret_valid   = 1'b1;
        @(negedge clk);
        checkBundle(e);
        checkOutput("req_low_issue", 32'(bus.imem_req), 32'd0);
      end
      bus.imem_rvalid = 1'b0;
      bus.ret_valid   = 1'b0;
      bus.id_ready    = 1'b1;
      @(negedge clk);
      bus.id_ready = 1'b0;
      checkOutput("valid_drop", 32'(bus.id_valid), 32'd0);
      bus.ret_valid    = 1'b1;
      bus.ret_wb_en    = v.retWbEn;
      bus.ret_wb_data  = v.retData;
      bus.ret_redirect = v.redirect;
      bus.ret_pc_new   = v.pcNew;
      @(negedge clk);
      bus.ret_valid = 1'b0;
      if (v.retWbEn && e.wbEn && e.wbDst != 5'd0) modelRf[e.wbDst] = v.retData;
      modelPc = v.redirect ? v.pcNew : modelPc + 16'd1;
    end else begin
      checkOutput("illegal_pulse", 32'(bus.illegal), 32'd1);
      checkOutput("illegal_no_valid", 32'(bus.id_valid), 32'd0);
      modelPc = modelPc + 16'd1;
    end
  endtask

  // Main sequence: reset values, instruction table, latency, reset during ISSUE
  initial begin
    vec_t rv;
    int   k;
    // op2 with r1 in its destination field [25:21], s2=r0, const 5
    vecs[0]  = '{32'h08200005, 1'b1, 1'b1, 5'd1, 0, 1'b1, 32'd5,        1'b0, 16'h0000};
    // op0 rs=1 rt=1 rd=2 funct0, ALU holds off ready for 3 cycles, redirect to 0x0010
    vecs[1]  = '{32'h00211000, 1'b1, 1'b1, 5'd2, 3, 1'b1, 32'd10,       1'b1, 16'h0010};
    vecs[2]  = '{32'h1C420000, 1'b1, 1'b0, 5'd0, 0, 1'b1, 32'h00001234, 1'b1, 16'h0040};
    vecs[3]  = '{32'h1C420000, 1'b1, 1'b0, 5'd0, 0, 1'b1, 32'h00001234, 1'b1, 16'h0010};
    vecs[4]  = '{32'h1C420000, 1'b1, 1'b0, 5'd0, 0, 1'b1, 32'd0,        1'b0, 16'h0000};
    vecs[5]  = '{32'hFC000000, 1'b0, 1'b0, 5'd0, 0, 1'b0, 32'd0,        1'b0, 16'h0000};
    vecs[6]  = '{32'h04000000, 1'b1, 1'b1, 5'd0, 0, 1'b1, 32'hDEADBEEF, 1'b1, 16'hFFFF};
    vecs[7]  = '{32'h00001808, 1'b1, 1'b1, 5'd3, 0, 1'b1, 32'h00000077, 1'b0, 16'h0000};
    vecs[8]  = '{32'h4064BEEF, 1'b1, 1'b1, 5'd4, 0, 1'b1, 32'h0000CAFE, 1'b0, 16'h0000};
    vecs[9]  = '{32'h00000009, 1'b0, 1'b0, 5'd0, 0, 1'b0, 32'd0,        1'b0, 16'h0000};
    vecs[10] = '{32'h00800028, 1'b1, 1'b1, 5'd0, 0, 1'b1, 32'h00000099, 1'b0, 16'h0000};
    vecs[11] = '{32'h44000000, 1'b0, 1'b0, 5'd0, 0, 1'b0, 32'd0,        1'b0, 16'h0000};
    vecs[12] = '{32'h10A007C0, 1'b1, 1'b1, 5'd5, 1, 1'b1, 32'h00000055, 1'b0, 16'h0000};

    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = 32'd0;
    bus.id_ready     = 1'b0;
    bus.ret_valid    = 1'b0;
    bus.ret_wb_en    = 1'b0;
    bus.ret_wb_data  = 32'd0;
    bus.ret_redirect = 1'b0;
    bus.ret_pc_new   = 16'd0;
    resetModel();
    rst_n = 1'b0;
    #12;
    checkOutput("rst_imem_req",  32'(bus.imem_req),  32'd0);
    checkOutput("rst_imem_addr", 32'(bus.imem_addr), 32'h0000);
    checkOutput("rst_id_valid",  32'(bus.id_valid),  32'd0);
    checkOutput("rst_illegal",   32'(bus.illegal),   32'd0);
    checkOutput("rst_id_opcode", 32'(bus.id_opcode), 32'd0);
    checkOutput("rst_id_s1",     bus.id_s1,          32'd0);
    checkOutput("rst_id_pc",     32'(bus.id_pc),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    checkOutput("latency_legal",   32'(fetchCycle[1] - fetchCycle[0]), 32'd4);
    checkOutput("latency_illegal", 32'(fetchCycle[6] - fetchCycle[5]), 32'd2);

    // Bring a legal instruction into ISSUE, then pull reset while it waits for ready
    k = 0;
    while (!bus.imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("pre_reset_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00211000;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    checkOutput("pre_reset_valid", 32'(bus.id_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_id_valid",  32'(bus.id_valid),  32'd0);
    checkOutput("midreset_id_opcode", 32'(bus.id_opcode), 32'd0);
    checkOutput("midreset_imem_req",  32'(bus.imem_req),  32'd0);
    checkOutput("midreset_imem_addr", 32'(bus.imem_addr), 32'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("post_reset_idle_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    checkOutput("post_reset_fetch_req",  32'(bus.imem_req),  32'd1);
    checkOutput("post_reset_fetch_addr", 32'(bus.imem_addr), 32'h0000);
    resetModel();
    // op0 rs=2 rt=1 rd=0: both registers were written earlier and must read 0 after reset
    rv = '{32'h00410000, 1'b1, 1'b1, 5'd0, 0, 1'b1, 32'd0, 1'b0, 16'h0000};
    applyStimulus(rv, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so a stuck handshake still ends with a summary line
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
